serial_adder_ctrl: RTL and testbench

Bit-serial add/subtract controller that sequences one one-bit full adder cell over WIDTH-bit operands, one bit per clock, LSB first. It provides a start/busy/done handshake, latches operands, manages the carry register and assembles the result in a shift register. It sits alongside the combinational adder blocks and trades WIDTH cycles of latency for a single adder cell.

---
 rtl/serial_adder_ctrl_pkg.sv | 13 +
 rtl/serial_adder_ctrl_if.sv | 29 ++
 rtl/serial_adder_ctrl_fa.sv | 24 ++
 rtl/serial_adder_ctrl.sv | 112 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// controller state encodings and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the serial adder controller. The master issues
// operands and start. The slave (the controller) returns status and the result.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry_out, overflow
    );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder built from two half adders. This is the only arithmetic
// cell in the serial datapath.
module FA_with_HA (
    input  logic A,
    input  logic B,
    input  logic Carry_in,
    output logic SUM,
    output logic Carry_out
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    // First half adder combines the operand bits, second adds the carry in
    always_comb begin
        ha1_sum   = A ^ B;
        ha1_carry = A & B;
        SUM       = ha1_sum ^ Carry_in;
        ha2_carry = ha1_sum & Carry_in;
        Carry_out = ha1_carry | ha2_carry;
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller. One full adder cell processes one bit
// per clock, LSB first. Each operation takes WIDTH RUN cycles followed by a
// one-cycle DONE. The visible result only changes on entry to DONE, so the
// previous answer stays readable while a new operation is running.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   sum_sr_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;
    logic               ovf_reg;

    logic               cell_sum;
    logic               cell_carry;
    logic               last_step;
    logic [WIDTH-1:0]   sum_sr_next;

    // Single adder cell fed from the LSBs of the operand shift registers
    FA_with_HA u_cell (
        .A        (a_reg[0]),
        .B        (b_reg[0]),
        .Carry_in (carry_reg),
        .SUM      (cell_sum),
        .Carry_out(cell_carry)
    );

    // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB
    always_comb begin
        sum_sr_next = {cell_sum, sum_sr_reg[WIDTH-1:1]};
        last_step   = (cnt_reg == CNT_W'(WIDTH - 1));
    end

    // Controller FSM, operand/result shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_sr_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                // DONE accepts start exactly like IDLE, which allows back-to-back operations
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        // Subtraction is A + ~B + 1: invert B and preload the carry with 1
                        a_reg     <= bus.a;
                        b_reg     <= bus.sub ? ~bus.b : bus.b;
                        carry_reg <= bus.sub;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                // start is ignored here: there is no queuing of requests
                ST_RUN: begin
                    a_reg      <= a_reg >> 1;
                    b_reg      <= b_reg >> 1;
                    carry_reg  <= cell_carry;
                    sum_sr_reg <= sum_sr_next;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_step) begin
                        // Carry into the MSB is carry_reg on this step. It differs from
                        // the carry out only on signed overflow.
                        sum_reg   <= sum_sr_next;
                        cout_reg  <= cell_carry;
                        ovf_reg   <= carry_reg ^ cell_carry;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.sum       = sum_reg;
    assign bus.carry_out = cout_reg;
    assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8). The stimulus pushes
// hand-computed results into a queue. A monitor pops and compares them on every
// done pulse. The stimulus side also checks latency, busy length and that the
// previous result is held during RUN.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t expq[$];

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive a request in the current cycle. The result is pushed only when a done is expected.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input bit push, input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.sub   = ts;
        bus.start = 1'b1;
        if (push) begin
            e.s = es;
            e.c = ec;
            e.o = eo;
            expq.push_back(e);
        end
        $display("issue a=%02h b=%02h sub=%0d expect sum=%02h c=%0d ovf=%0d", ta, tb_v, ts, es, ec, eo);
    endtask

    // Follow one operation from its start edge to the done cycle. start is kept
    // high with junk operands for `hold` RUN cycles. Returns at the negedge where done is seen.
    task automatic wait_done(input int hold, input logic [W-1:0] held_sum);
        int n;
        int busy_n;
        bit held_ok;
        @(posedge clk);
        n       = 1;
        busy_n  = 0;
        held_ok = 1'b1;
        @(negedge clk);
        bus.start = (hold > 0);
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.sub   = 1'b0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_n++;
            if (bus.sum !== held_sum) held_ok = 1'b0;
            @(negedge clk);
            n++;
            if (n > hold) bus.start = 1'b0;
        end
        chk("done_latency", n, 9);
        chk("busy_cycles", busy_n, 8);
        chk("sum_held_in_run", {31'd0, held_ok}, 1);
    endtask

    // Scoreboard monitor: compare every done pulse against the oldest expectation
    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                chk("done_one_cycle", {31'd0, prev_done}, 0);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=sum %02h required=no done", bus.sum);
                end else begin
                    e = expq.pop_front();
                    chk("sum", {24'd0, bus.sum}, {24'd0, e.s});
                    chk("carry_out", {31'd0, bus.carry_out}, {31'd0, e.c});
                    chk("overflow", {31'd0, bus.overflow}, {31'd0, e.o});
                    $display("done sum=%02h c=%0d ovf=%0d (expected %02h %0d %0d)",
                             bus.sum, bus.carry_out, bus.overflow, e.s, e.c, e.o);
                end
            end
            prev_done = bus.done;
        end
    end

    // Hard stop in case the stimulus itself gets stuck
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_done", {31'd0, bus.done}, 0);
        chk("rst_sum", {24'd0, bus.sum}, 0);
        chk("rst_carry", {31'd0, bus.carry_out}, 0);
        chk("rst_ovf", {31'd0, bus.overflow}, 0);
        rst = 1'b0;

        // Plain add
        @(negedge clk); issue(8'h3C, 8'h05, 1'b0, 1, 8'h41, 1'b0, 1'b0); wait_done(0, 8'h00);
        // Unsigned wrap
        @(negedge clk); issue(8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0); wait_done(0, 8'h41);
        // Signed overflow on add
        @(negedge clk); issue(8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, 1'b1); wait_done(0, 8'h00);
        // Subtract with borrow
        @(negedge clk); issue(8'h05, 8'h07, 1'b1, 1, 8'hFE, 1'b0, 1'b0); wait_done(0, 8'h80);
        // Subtract with signed overflow
        @(negedge clk); issue(8'h80, 8'h01, 1'b1, 1, 8'h7F, 1'b1, 1'b1); wait_done(0, 8'hFE);
        // start held during RUN with other operands must be ignored
        @(negedge clk); issue(8'h12, 8'h34, 1'b0, 1, 8'h46, 1'b0, 1'b0); wait_done(4, 8'h7F);
        repeat (12) @(negedge clk);

        // Back-to-back: second start issued in the DONE cycle
        @(negedge clk); issue(8'hA0, 8'h50, 1'b0, 1, 8'hF0, 1'b0, 1'b0); wait_done(0, 8'h46);
        issue(8'h10, 8'h20, 1'b0, 1, 8'h30, 1'b0, 1'b0); wait_done(0, 8'hF0);

        // Reset after three RUN steps: outputs clear at once and no done follows
        @(negedge clk); issue(8'h55, 8'h11, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, bus.busy}, 0);
        chk("async_rst_done", {31'd0, bus.done}, 0);
        chk("async_rst_sum", {24'd0, bus.sum}, 0);
        chk("async_rst_carry", {31'd0, bus.carry_out}, 0);
        chk("async_rst_ovf", {31'd0, bus.overflow}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Normal operation after reset
        @(negedge clk); issue(8'h01, 8'h01, 1'b0, 1, 8'h02, 1'b0, 1'b0); wait_done(0, 8'h00);

        repeat (5) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
